// File: rtl/tile_transpose_collector.sv
// Collects N rows of N elements into one NxN tile, emitted transposed: element (r,c) -> flat c*N+r.
// Define TILE_DOUBLE_BUF_EN for a ping-pong build that keeps filling while a finished tile waits.
module tile_transpose_collector #(
    parameter int N = 4,
    parameter int W = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             row_valid_i,
    output logic             row_ready_o,
    input  logic [N*W-1:0]   row_data_i,
    output logic             tile_valid_o,
    input  logic             tile_ready_i,
    output logic [N*N*W-1:0] tile_o
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Both sides use valid/ready: a transfer happens on a rising edge where valid and ready
    // are both high; a producer holds data stable until then, and ready never depends on valid.
    typedef enum logic {FILL, FULL} state_t;

    state_t           state;
    logic [CW-1:0]    row_cnt;
    logic [N*N*W-1:0] fill_buf;
    logic [N*N*W-1:0] fill_next;
    logic             row_take;
    logic             tile_take;
    logic             last_row;

    // A flush in the same cycle as a row drops that row.
    assign row_take  = row_valid_i & row_ready_o & ~flush_i;
    assign tile_take = tile_valid_o & tile_ready_i;
    assign last_row  = (row_cnt == CW'(N - 1));

    // The fill buffer is kept already transposed: row r lands in column slot r.
    always_comb begin
        fill_next = fill_buf;
        for (int c = 0; c < N; c++) begin
            fill_next[(c * N + int'(row_cnt)) * W +: W] = row_data_i[c * W +: W];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= FILL;
            row_cnt      <= '0;
            fill_buf     <= '0;
            tile_o       <= '0;
            tile_valid_o <= 1'b0;
            row_ready_o  <= 1'b1;
        end else begin
            case (state)
                FILL: begin
`ifdef TILE_DOUBLE_BUF_EN
                    if (tile_take) begin
                        tile_valid_o <= 1'b0;
                    end
`endif
                    if (flush_i) begin
                        row_cnt  <= '0;
                        fill_buf <= '0;
                    end else if (row_take) begin
                        if (last_row) begin
                            row_cnt  <= '0;
                            fill_buf <= '0;
`ifdef TILE_DOUBLE_BUF_EN
                            // Output slot free (or freeing now): present with no bubble.
                            if (!tile_valid_o || tile_ready_i) begin
                                tile_o       <= fill_next;
                                tile_valid_o <= 1'b1;
                            end else begin
                                fill_buf    <= fill_next;
                                row_ready_o <= 1'b0;
                                state       <= FULL;
                            end
`else
                            tile_o       <= fill_next;
                            tile_valid_o <= 1'b1;
                            row_ready_o  <= 1'b0;
                            state        <= FULL;
`endif
                        end else begin
                            row_cnt  <= row_cnt + CW'(1);
                            fill_buf <= fill_next;
                        end
                    end
                end
                FULL: begin
                    // A complete tile is never touched by flush.
                    if (tile_take) begin
`ifdef TILE_DOUBLE_BUF_EN
                        tile_o   <= fill_buf;
                        fill_buf <= '0;
`else
                        tile_valid_o <= 1'b0;
`endif
                        row_ready_o <= 1'b1;
                        state       <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_transpose_collector.sv
// Bench for tile_transpose_collector: queue-based reference model checked every cycle,
// directed literal cases, then randomized traffic over 1000 tiles.
module tb_tile_transpose_collector;
    localparam int N = 4;
    localparam int W = 1;
`ifdef TILE_DOUBLE_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             row_valid = 1'b0;
    logic             row_ready_o;
    logic [N*W-1:0]   row_data = '0;
    logic             tile_valid_o;
    logic             tile_ready = 1'b1;
    logic [N*N*W-1:0] tile_o;

    int total = 0;
    int bad = 0;
    int dut_tiles = 0;
    int model_tiles = 0;

    tile_transpose_collector #(.N(N), .W(W)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .flush_i(flush),
        .row_valid_i(row_valid),
        .row_ready_o(row_ready_o),
        .row_data_i(row_data),
        .tile_valid_o(tile_valid_o),
        .tile_ready_i(tile_ready),
        .tile_o(tile_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: tiles held = queue of completed tiles, presented one is the head.
    logic [N*N*W-1:0] exp_q[$];
    logic [N*W-1:0]   part_rows[N];
    int               part_n = 0;
    logic [N*N*W-1:0] shown = '0;
    logic             exp_ready = 1'b1;
    logic             exp_valid = 1'b0;

    function automatic logic [N*N*W-1:0] build(input logic [N*W-1:0] rows[N]);
        logic [N*N*W-1:0] t;
        t = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                t[(c * N + r) * W +: W] = rows[r][c * W +: W];
        return t;
    endfunction

    always @(posedge clk) begin
        logic racc;
        logic tacc;
        if (rst) begin
            exp_q.delete();
            part_n    = 0;
            shown     = '0;
            exp_ready = 1'b1;
            exp_valid = 1'b0;
        end else begin
            racc = row_valid && exp_ready && !flush;
            tacc = exp_valid && tile_ready;
            if (tacc) begin
                exp_q.delete(0);
                model_tiles++;
            end
            if (flush) begin
                part_n = 0;
            end else if (racc) begin
                part_rows[part_n] = row_data;
                part_n++;
                if (part_n == N) begin
                    exp_q.push_back(build(part_rows));
                    part_n = 0;
                end
            end
            exp_valid = (exp_q.size() > 0);
            exp_ready = (exp_q.size() < CAP);
            if (exp_valid) shown = exp_q[0];
        end
    end

    // Compare process: every cycle, just after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("row_ready", 64'(row_ready_o), 64'(exp_ready));
            check("tile_valid", 64'(tile_valid_o), 64'(exp_valid));
            check("tile_o", 64'(tile_o), 64'(shown));
        end
    end

    always @(negedge clk) begin
        if (!rst && tile_valid_o && tile_ready) dut_tiles++;
    end

    // Called at a negedge; returns at the negedge after the row was accepted.
    task automatic put_row(input logic [N*W-1:0] d);
        int k;
        k = 0;
        while (!row_ready_o && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!row_ready_o) begin
            total++;
            bad++;
            $display("FAIL row_wait: row_ready stuck at 0 after %0d cycles", k);
        end
        row_valid = 1'b1;
        row_data  = d;
        @(negedge clk);
        row_valid = 1'b0;
        row_data  = (N*W)'($urandom());
    endtask

    task automatic put_tile(input logic [15:0] rows);
        for (int r = 0; r < N; r++) put_row(rows[r*4 +: 4]);
    endtask

    initial begin
        logic [15:0] pat_rows[3];
        logic [15:0] pat_tile[3];
        int snap;
        int cyc;

        repeat (3) @(negedge clk);
        check("reset_row_ready", 64'(row_ready_o), 64'(1));
        check("reset_tile_valid", 64'(tile_valid_o), 64'(0));
        check("reset_tile_o", 64'(tile_o), 64'(0));
        rst = 1'b0;

        // Diagonal rows land on the diagonal of the flat word.
        tile_ready = 1'b1;
        put_tile(16'h8421);
        check("t1_valid", 64'(tile_valid_o), 64'(1));
        check("t1_tile", 64'(tile_o), 64'h8421);
`ifdef TILE_DOUBLE_BUF_EN
        check("t1_ready_full", 64'(row_ready_o), 64'(1));
`else
        check("t1_ready_full", 64'(row_ready_o), 64'(0));
`endif
        @(negedge clk);
        check("t1_valid_drop", 64'(tile_valid_o), 64'(0));
        check("t1_ready_back", 64'(row_ready_o), 64'(1));
        check("t1_tile_kept", 64'(tile_o), 64'h8421);

        // Row 0 all ones -> flat bits 0,4,8,12; column 0 of every row -> bits 0..3.
        pat_rows[0] = 16'h000F; pat_tile[0] = 16'h1111;
        pat_rows[1] = 16'h1111; pat_tile[1] = 16'h000F;
        pat_rows[2] = 16'h8888; pat_tile[2] = 16'hF000;
        for (int p = 0; p < 3; p++) begin
            put_tile(pat_rows[p]);
            check("t2_tile", 64'(tile_o), 64'(pat_tile[p]));
            @(negedge clk);
        end

        // Back-pressure: tile held stable.
        tile_ready = 1'b0;
        put_tile(16'h8421);
        for (int i = 0; i < 10; i++) begin
            check("t3_valid_hold", 64'(tile_valid_o), 64'(1));
            check("t3_tile_hold", 64'(tile_o), 64'h8421);
`ifndef TILE_DOUBLE_BUF_EN
            check("t3_ready_low", 64'(row_ready_o), 64'(0));
`endif
            @(negedge clk);
        end
`ifdef TILE_DOUBLE_BUF_EN
        put_tile(16'h1111);
        check("t3_second_full", 64'(row_ready_o), 64'(0));
        check("t3_tile_still", 64'(tile_o), 64'h8421);
        tile_ready = 1'b1;
        @(negedge clk);
        check("t3_next_valid", 64'(tile_valid_o), 64'(1));
        check("t3_next_tile", 64'(tile_o), 64'h000F);
        @(negedge clk);
`else
        tile_ready = 1'b1;
        @(negedge clk);
`endif
        check("t3_drained", 64'(tile_valid_o), 64'(0));
        check("t3_ready_back", 64'(row_ready_o), 64'(1));

        // Flush with a same-cycle row discards the partial tile and that row.
        snap = dut_tiles;
        put_row(4'h3);
        put_row(4'h5);
        flush     = 1'b1;
        row_valid = 1'b1;
        row_data  = 4'hF;
        @(negedge clk);
        flush     = 1'b0;
        row_valid = 1'b0;
        put_tile(16'h8421);
        check("t4_tile", 64'(tile_o), 64'h8421);
        repeat (3) @(negedge clk);
        check("t4_one_tile", 64'(dut_tiles - snap), 64'(1));

        // Reset while a tile is presented and rows are pending.
        tile_ready = 1'b0;
        put_tile(16'h8421);
`ifdef TILE_DOUBLE_BUF_EN
        put_row(4'h3);
        put_row(4'h5);
`endif
        rst       = 1'b1;
        row_valid = 1'b1;
        row_data  = 4'h7;
        @(negedge clk);
        rst       = 1'b0;
        row_valid = 1'b0;
        check("t5_valid", 64'(tile_valid_o), 64'(0));
        check("t5_ready", 64'(row_ready_o), 64'(1));
        check("t5_tile", 64'(tile_o), 64'(0));
        tile_ready = 1'b1;
        snap = dut_tiles;
        put_tile(16'h8888);
        check("t5_new_tile", 64'(tile_o), 64'hF000);
        repeat (3) @(negedge clk);
        check("t5_one_tile", 64'(dut_tiles - snap), 64'(1));

        // Random traffic.
        snap = dut_tiles;
        cyc  = 0;
        while (dut_tiles - snap < 1000 && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            row_valid  = ($urandom_range(0, 3) != 0);
            row_data   = (N*W)'($urandom());
            tile_ready = ($urandom_range(0, 2) != 0);
        end
        check("t6_cycle_budget", 64'(cyc < 40000), 64'(1));
        row_valid  = 1'b0;
        tile_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("t6_tile_count", 64'(dut_tiles), 64'(model_tiles));
        check("t6_model_empty", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
